// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32IMF core.
// Sequences fetch, decode, ALU execute, data-memory access, mul/div and FPU waits and writeback,
// and drives the datapath selects and write enables for each phase.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   opcode, funct7, br_taken   instruction fields from the IR and the branch compare result
//   imem_req/imem_ack, ir_we   instruction fetch handshake and IR load strobe
//   dmem_req/dmem_we/dmem_ack  data access handshake (dmem_we = 1 for stores)
//   md_start/md_done           mul/div unit start pulse and completion
//   fp_start/fp_done           FPU start pulse and completion
//   alu_b_imm, alu_a_pc        ALU operand selects
//   wb_sel, rf_we, frf_we      writeback source and register-file write enables
//   pc_we, pc_sel              PC update strobe and next-PC source
//   halted, err_code           stop indication and reason (1 illegal, 2 timeout, 3 ECALL/EBREAK)
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       md_start,
  input  logic       md_done,
  output logic       fp_start,
  input  logic       fp_done,
  output logic       alu_b_imm,
  output logic       alu_a_pc,
  output logic [1:0] wb_sel,
  output logic       rf_we,
  output logic       frf_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       halted,
  output logic [1:0] err_code
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpFlw    = 7'b0000111;
  localparam logic [6:0] OpFsw    = 7'b0100111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFp     = 7'b1010011;
  localparam logic [6:0] OpFmadd  = 7'b1000011;
  localparam logic [6:0] OpFmsub  = 7'b1000111;
  localparam logic [6:0] OpFnmsub = 7'b1001011;
  localparam logic [6:0] OpFnmadd = 7'b1001111;

  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrIllegal = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrSystem  = 2'd3;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbMem  = 2'd1;
  localparam logic [1:0] WbPc4  = 2'd2;
  localparam logic [1:0] WbUnit = 2'd3;

  localparam logic [1:0] PcPlus4 = 2'd0;
  localparam logic [1:0] PcImm   = 2'd1;
  localparam logic [1:0] PcReg   = 2'd2;

  localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StMdWait,
    StFpWait,
    StWb,
    StHalt
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    opc_q, opc_d;
  logic [6:0]    f7_q, f7_d;
  logic [1:0]    err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          hs_done;
  logic          is_wait;

  function automatic logic is_fp_op(input logic [6:0] op);
    return op inside {OpFp, OpFmadd, OpFmsub, OpFnmsub, OpFnmadd};
  endfunction

  function automatic logic is_exec_op(input logic [6:0] op);
    return op inside {OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore, OpFlw, OpFsw,
                      OpImm, OpOp};
  endfunction

  function automatic logic is_store_op(input logic [6:0] op);
    return op inside {OpStore, OpFsw};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opc_q   <= '0;
      f7_q    <= '0;
      err_q   <= ErrNone;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      f7_q    <= f7_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign is_wait  = state_q inside {StFetch, StMem, StMdWait, StFpWait};
  assign err_code = err_q;

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    f7_d      = f7_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    hs_done   = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    md_start  = 1'b0;
    fp_start  = 1'b0;
    alu_b_imm = 1'b0;
    alu_a_pc  = 1'b0;
    wb_sel    = WbAlu;
    rf_we     = 1'b0;
    frf_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PcPlus4;
    halted    = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        imem_req = 1'b1;
        hs_done  = imem_ack;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        // IR is stable from here on; keep a private copy so later phases do not depend on it.
        opc_d = opcode;
        f7_d  = funct7;
        if (opcode == OpOp && funct7 == F7MulDiv) begin
          md_start = 1'b1;
          state_d  = StMdWait;
        end else if (is_fp_op(opcode)) begin
          fp_start = 1'b1;
          state_d  = StFpWait;
        end else if (opcode == OpSystem) begin
          err_d   = ErrSystem;
          state_d = StHalt;
        end else if (is_exec_op(opcode)) begin
          state_d = StExec;
        end else begin
          err_d   = ErrIllegal;
          state_d = StHalt;
        end
      end

      StExec: begin
        alu_b_imm = !(opc_q inside {OpOp, OpBranch});
        alu_a_pc  = (opc_q == OpAuipc);
        if (opc_q == OpBranch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? PcImm : PcPlus4;
          state_d = StFetch;
        end else if (opc_q inside {OpLoad, OpStore, OpFlw, OpFsw}) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end

      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = is_store_op(opc_q);
        hs_done  = dmem_ack;
        if (dmem_ack) begin
          if (is_store_op(opc_q)) begin
            // Stores have nothing to write back, so they retire here.
            pc_we   = 1'b1;
            pc_sel  = PcPlus4;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end

      StMdWait: begin
        hs_done = md_done;
        if (md_done) state_d = StWb;
      end

      StFpWait: begin
        hs_done = fp_done;
        if (fp_done) state_d = StWb;
      end

      StWb: begin
        pc_we = 1'b1;
        if (opc_q == OpJal) begin
          pc_sel = PcImm;
          wb_sel = WbPc4;
          rf_we  = 1'b1;
        end else if (opc_q == OpJalr) begin
          pc_sel = PcReg;
          wb_sel = WbPc4;
          rf_we  = 1'b1;
        end else if (opc_q == OpLoad) begin
          wb_sel = WbMem;
          rf_we  = 1'b1;
        end else if (opc_q == OpFlw) begin
          wb_sel = WbMem;
          frf_we = 1'b1;
        end else if (is_fp_op(opc_q)) begin
          wb_sel = WbUnit;
          // Compares, FCVT.W[U].S and FMV.X.W/FCLASS produce integer results.
          if (f7_q[6:2] inside {5'b10100, 5'b11000, 5'b11100}) rf_we = 1'b1;
          else                                               frf_we = 1'b1;
        end else if (opc_q == OpOp && f7_q == F7MulDiv) begin
          wb_sel = WbUnit;
          rf_we  = 1'b1;
        end else begin
          wb_sel = WbAlu;
          rf_we  = 1'b1;
        end
        state_d = StFetch;
      end

      StHalt: halted = 1'b1;

      default: state_d = StIdle;
    endcase

    // Shared wait-state timeout: the request stays up through the final counted cycle.
    if (is_wait && !hs_done) begin
      if (cnt_q == TimeoutCnt) begin
        err_d   = ErrTimeout;
        state_d = StHalt;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end

    if (state_d != state_q && state_d inside {StFetch, StMem, StMdWait, StFpWait}) begin
      cnt_d = '0;
    end
  end

endmodule
